regfile_wb_arbiter: RTL and testbench
=====================================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 The block SHALL have parameter STARVE_LIMIT, default 4: the number of consecutive buffered-pending cycles with a primary grant that forces a secondary write.
REQ-002 clk  input  1  clock; all state SHALL update on the rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 p_we  input  1  primary (pipeline writeback) write request.
REQ-005 p_waddr  input  5  primary destination register.
REQ-006 p_wdata  input  32  primary write data.
REQ-007 s_valid  input  1  secondary (long-latency unit) write valid.
REQ-008 s_ready  output  1  secondary accept; SHALL equal !full.
REQ-009 s_waddr  input  5  secondary destination register.
REQ-010 s_wdata  input  32  secondary write data.
REQ-011 rsv_en  input  1  reservation strobe: register rsv_addr awaits a secondary result.
REQ-012 rsv_addr  input  5  register being reserved.
REQ-013 rf_we  output  1  register file write enable.
REQ-014 rf_waddr  output  5  register file write address.
REQ-015 rf_wdata  output  32  register file write data.
REQ-016 stall_req  output  1  registered; primary pipeline hold request.
REQ-017 pending  output  32  per-register reservation bitmap; bit 0 SHALL always be 0.

Function
REQ-018 The block SHALL contain a 2-entry FIFO of {addr, data}; a push SHALL occur when s_valid && s_ready && s_waddr != 0.
REQ-019 When s_valid && s_ready && s_waddr == 0, the transfer SHALL be accepted and discarded, with no push and no pending change.
REQ-020 s_ready SHALL be 0 when the FIFO is full, including a cycle in which a pop occurs (no same-cycle push-on-full).
REQ-021 A pushed entry SHALL be eligible for grant no earlier than the next cycle, giving a minimum latency of 1 cycle from s_valid to rf_we.
REQ-022 A primary request SHALL be defined as p_we && p_waddr != 0; a primary write to r0 SHALL be treated as no request.
REQ-023 The FSM SHALL have two states, NORMAL and FORCE, and stall_req SHALL be 1 exactly while in FORCE.
REQ-024 In NORMAL, a primary request SHALL be granted; otherwise a non-empty FIFO head SHALL be granted and popped; otherwise rf_we SHALL be 0.
REQ-025 The grant mux SHALL be combinational, so a primary write reaches rf_* in the same cycle with 0 latency.
REQ-026 The 3-bit starve counter SHALL increment on each NORMAL cycle in which the FIFO is non-empty and the primary is granted.
REQ-027 The starve counter SHALL clear on any pop or when the FIFO is empty.
REQ-028 When the starve counter would reach STARVE_LIMIT, the next state SHALL be FORCE.
REQ-029 In FORCE, the FIFO head SHALL be granted and popped regardless of p_we; the primary is held by the pipeline and is not lost.
REQ-030 From FORCE, the next state SHALL be NORMAL with the counter at 0; FORCE SHALL last exactly 1 cycle.
REQ-031 rsv_en with rsv_addr != 0 SHALL set pending[rsv_addr] at the next edge; a reservation of r0 SHALL be ignored.
REQ-032 A pop of an entry with address A SHALL clear pending[A] at the next edge.
REQ-033 When a set and a clear of the same bit occur in the same cycle, the set SHALL win.
REQ-034 The FIFO SHALL preserve order: pops SHALL occur in push order, with head and tail pointers wrapping modulo 2.
REQ-035 rf_we SHALL never be 1 with rf_waddr == 0.

Reset
REQ-036 On rst, the FIFO SHALL be emptied, the counter cleared and the FSM set to NORMAL.
REQ-037 On rst, pending SHALL be 0 and stall_req SHALL be 0.
REQ-038 While rst is high, rf_we SHALL be 0, rf_waddr SHALL be 0, rf_wdata SHALL be 0 and s_ready SHALL be 0.
REQ-039 A reset asserted mid-operation SHALL drop buffered entries and perform no write that cycle.
REQ-040 In the first cycle after rst deasserts, s_ready SHALL be 1.

Verification
REQ-041 The bench SHALL cover: p_we=1, p_waddr=5, p_wdata=0xA5A5A5A5 with an empty FIFO -> same cycle rf_we=1, rf_waddr=5, rf_wdata=0xA5A5A5A5.
REQ-042 The bench SHALL cover: rsv_en to r7, then s_valid with addr 7, data 0x1234 and no primary -> rf_we the next cycle with addr 7, data 0x1234; pending[7] goes 1 then 0.
REQ-043 The bench SHALL cover: 3 back-to-back secondary pushes with continuous primary requests -> s_ready=0 after 2 pushes; after 4 primary grants stall_req=1 for 1 cycle while the head is written; ordering is preserved.
REQ-044 The bench SHALL cover: a same-cycle rsv_en to r9 and a pop of r9 -> pending[9]=1.
REQ-045 The bench SHALL cover: secondary transfers to r0 and primary writes to r0 -> no rf_we, no FIFO occupancy, s_ready stays 1.
REQ-046 The bench SHALL cover: rst asserted with 2 entries buffered -> next cycle FIFO empty, pending=0, no rf_we; after deassert, s_ready=1.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter.
// A primary (pipeline) write port and a secondary (long-latency unit) port
// share one register-file write port. Secondary results are buffered in a
// 2-entry FIFO. A starvation counter forces a one-cycle pipeline stall so
// buffered results are eventually written. A per-register pending bitmap
// tracks registers that are waiting for a secondary result.
module regfile_wb_arbiter #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        p_we,
   input  logic [4:0]  p_waddr,
   input  logic [31:0] p_wdata,
   input  logic        s_valid,
   output logic        s_ready,
   input  logic [4:0]  s_waddr,
   input  logic [31:0] s_wdata,
   input  logic        rsv_en,
   input  logic [4:0]  rsv_addr,
   output logic        rf_we,
   output logic [4:0]  rf_waddr,
   output logic [31:0] rf_wdata,
   output logic        stall_req,
   output logic [31:0] pending
);

   typedef enum logic [0:0] {
      NORMAL = 1'b0,
      FORCE  = 1'b1
   } state_t;

   localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

   state_t      state, next_state;
   logic [2:0]  starve_cnt, starve_cnt_next;
   logic        stall_r;

   logic [4:0]  fifo_addr [2];
   logic [31:0] fifo_data [2];
   logic        head, tail;
   logic [1:0]  count;
   logic        full, empty;
   logic        push, pop;
   logic        p_req;

   logic [31:0] pending_r, pending_next;
   logic [31:0] set_mask, clr_mask;

   assign full      = (count == 2'd2);
   assign empty     = (count == 2'd0);
   // No push while full, even if the head pops this cycle; nothing accepted in reset.
   assign s_ready   = !full && !rst;
   // Transfers to r0 are accepted but never buffered.
   assign push      = s_valid && s_ready && (s_waddr != 5'd0);
   // Writes to r0 are not real requests.
   assign p_req     = p_we && (p_waddr != 5'd0);
   assign stall_req = stall_r;
   assign pending   = pending_r;

   // Grant mux, pop decision, starve counter and next-state logic.
   always_comb begin
      next_state      = state;
      starve_cnt_next = starve_cnt;
      pop             = 1'b0;
      rf_we           = 1'b0;
      rf_waddr        = 5'd0;
      rf_wdata        = 32'd0;
      if (rst) begin
         next_state      = NORMAL;
         starve_cnt_next = 3'd0;
      end else begin
         case (state)
            NORMAL: begin
               if (p_req) begin
                  rf_we    = 1'b1;
                  rf_waddr = p_waddr;
                  rf_wdata = p_wdata;
               end else if (!empty) begin
                  pop      = 1'b1;
                  rf_we    = 1'b1;
                  rf_waddr = fifo_addr[head];
                  rf_wdata = fifo_data[head];
               end else begin
                  rf_we    = 1'b0;
               end
               // Count only cycles where a buffered entry lost to the primary.
               if (p_req && !empty) begin
                  if ((starve_cnt + 3'd1) == LIMIT) begin
                     next_state      = FORCE;
                     starve_cnt_next = 3'd0;
                  end else begin
                     starve_cnt_next = starve_cnt + 3'd1;
                  end
               end else begin
                  starve_cnt_next = 3'd0;
               end
            end
            FORCE: begin
               // Pipeline is held by stall_req, so the primary is not lost.
               if (!empty) begin
                  pop      = 1'b1;
                  rf_we    = 1'b1;
                  rf_waddr = fifo_addr[head];
                  rf_wdata = fifo_data[head];
               end else begin
                  rf_we    = 1'b0;
               end
               next_state      = NORMAL;
               starve_cnt_next = 3'd0;
            end
            default: begin
               next_state      = NORMAL;
               starve_cnt_next = 3'd0;
            end
         endcase
      end
   end

   // FSM state, starve counter and registered stall request.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= NORMAL;
         starve_cnt <= 3'd0;
         stall_r    <= 1'b0;
      end else begin
         state      <= next_state;
         starve_cnt <= starve_cnt_next;
         stall_r    <= (next_state == FORCE);
      end
   end

   // FIFO pointers and occupancy; pointers wrap modulo 2.
   always_ff @(posedge clk) begin
      if (rst) begin
         head  <= 1'b0;
         tail  <= 1'b0;
         count <= 2'd0;
      end else begin
         if (push) begin
            tail <= ~tail;
         end else begin
            tail <= tail;
         end
         if (pop) begin
            head <= ~head;
         end else begin
            head <= head;
         end
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   // FIFO storage; contents are only meaningful below the occupancy count.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_addr[tail] <= s_waddr;
         fifo_data[tail] <= s_wdata;
      end else begin
         fifo_addr[tail] <= fifo_addr[tail];
         fifo_data[tail] <= fifo_data[tail];
      end
   end

   // Pending bitmap update: a reservation set wins over a pop clear.
   always_comb begin
      set_mask = 32'd0;
      clr_mask = 32'd0;
      if (rsv_en && (rsv_addr != 5'd0)) begin
         set_mask[rsv_addr] = 1'b1;
      end else begin
         set_mask = 32'd0;
      end
      if (pop) begin
         clr_mask[fifo_addr[head]] = 1'b1;
      end else begin
         clr_mask = 32'd0;
      end
      pending_next    = (pending_r & ~clr_mask) | set_mask;
      pending_next[0] = 1'b0;
   end

   // Pending bitmap register.
   always_ff @(posedge clk) begin
      if (rst) begin
         pending_r <= 32'd0;
      end else begin
         pending_r <= pending_next;
      end
   end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter.
// Inputs change just after the falling edge; outputs are checked 1 time unit later.
module tb_regfile_wb_arbiter;

   logic        clk;
   logic        rst;
   logic        p_we;
   logic [4:0]  p_waddr;
   logic [31:0] p_wdata;
   logic        s_valid;
   logic        s_ready;
   logic [4:0]  s_waddr;
   logic [31:0] s_wdata;
   logic        rsv_en;
   logic [4:0]  rsv_addr;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic        stall_req;
   logic [31:0] pending;

   int n_total = 0;
   int n_pass  = 0;
   int n_fail  = 0;

   regfile_wb_arbiter #(.STARVE_LIMIT(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .p_we      (p_we),
      .p_waddr   (p_waddr),
      .p_wdata   (p_wdata),
      .s_valid   (s_valid),
      .s_ready   (s_ready),
      .s_waddr   (s_waddr),
      .s_wdata   (s_wdata),
      .rsv_en    (rsv_en),
      .rsv_addr  (rsv_addr),
      .rf_we     (rf_we),
      .rf_waddr  (rf_waddr),
      .rf_wdata  (rf_wdata),
      .stall_req (stall_req),
      .pending   (pending)
   );

   // Free-running clock, period 10.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Directed stimulus sequence.
   initial begin
      rst = 1'b1; p_we = 1'b0; p_waddr = 5'd0; p_wdata = 32'd0;
      s_valid = 1'b0; s_waddr = 5'd0; s_wdata = 32'd0;
      rsv_en = 1'b0; rsv_addr = 5'd0;

      // Reset state, with a primary request driven to prove gating.
      tick(); p_we = 1'b1; p_waddr = 5'd3; p_wdata = 32'h33; #1;
      chk("rst_rf_we", rf_we, 1'b0);
      chk("rst_rf_waddr", rf_waddr, 5'd0);
      chk("rst_rf_wdata", rf_wdata, 32'd0);
      chk("rst_s_ready", s_ready, 1'b0);
      chk("rst_stall", stall_req, 1'b0);
      chk("rst_pending", pending, 32'd0);
      tick(); rst = 1'b0; p_we = 1'b0; #1;
      chk("post_rst_s_ready", s_ready, 1'b1);
      chk("post_rst_rf_we", rf_we, 1'b0);

      // Primary write with empty FIFO: zero latency.
      tick(); p_we = 1'b1; p_waddr = 5'd5; p_wdata = 32'hA5A5A5A5; #1;
      chk("prim_we", rf_we, 1'b1);
      chk("prim_waddr", rf_waddr, 5'd5);
      chk("prim_wdata", rf_wdata, 32'hA5A5A5A5);

      // Reserve r7, secondary write to r7, written the next cycle.
      tick(); p_we = 1'b0; rsv_en = 1'b1; rsv_addr = 5'd7; #1;
      chk("rsv7_before", pending[7], 1'b0);
      tick(); rsv_en = 1'b0; s_valid = 1'b1; s_waddr = 5'd7; s_wdata = 32'h1234; #1;
      chk("rsv7_set", pending[7], 1'b1);
      chk("sec_not_same_cycle", rf_we, 1'b0);
      chk("sec_s_ready", s_ready, 1'b1);
      tick(); s_valid = 1'b0; #1;
      chk("sec_we", rf_we, 1'b1);
      chk("sec_waddr", rf_waddr, 5'd7);
      chk("sec_wdata", rf_wdata, 32'h1234);
      chk("rsv7_still", pending[7], 1'b1);
      tick(); #1;
      chk("rsv7_cleared", pending[7], 1'b0);
      chk("sec_done_we", rf_we, 1'b0);

      // Writes to r0 on both ports are ignored.
      tick(); s_valid = 1'b1; s_waddr = 5'd0; s_wdata = 32'hDEAD;
      p_we = 1'b1; p_waddr = 5'd0; p_wdata = 32'hBEEF; #1;
      chk("r0_we_a", rf_we, 1'b0);
      chk("r0_s_ready_a", s_ready, 1'b1);
      tick(); #1;
      chk("r0_we_b", rf_we, 1'b0);
      chk("r0_s_ready_b", s_ready, 1'b1);
      tick(); s_valid = 1'b0; p_we = 1'b0; #1;
      chk("r0_fifo_empty", rf_we, 1'b0);

      // Starvation: continuous primary, three secondary pushes.
      tick(); p_we = 1'b1; p_waddr = 5'd1; p_wdata = 32'h11;
      s_valid = 1'b1; s_waddr = 5'd10; s_wdata = 32'hAAA; #1;
      chk("st_c0_ready", s_ready, 1'b1);
      chk("st_c0_waddr", rf_waddr, 5'd1);
      tick(); s_waddr = 5'd11; s_wdata = 32'hBBB; #1;
      chk("st_c1_ready", s_ready, 1'b1);
      chk("st_c1_stall", stall_req, 1'b0);
      tick(); s_waddr = 5'd12; s_wdata = 32'hCCC; #1;
      chk("st_c2_full", s_ready, 1'b0);
      tick(); #1;
      chk("st_c3_full", s_ready, 1'b0);
      chk("st_c3_stall", stall_req, 1'b0);
      tick(); #1;
      chk("st_c4_stall", stall_req, 1'b0);
      chk("st_c4_waddr", rf_waddr, 5'd1);
      tick(); #1;
      chk("st_c5_stall", stall_req, 1'b1);
      chk("st_c5_we", rf_we, 1'b1);
      chk("st_c5_waddr", rf_waddr, 5'd10);
      chk("st_c5_wdata", rf_wdata, 32'hAAA);
      chk("st_c5_no_push_on_pop", s_ready, 1'b0);
      tick(); #1;
      chk("st_c6_stall", stall_req, 1'b0);
      chk("st_c6_ready", s_ready, 1'b1);
      chk("st_c6_waddr", rf_waddr, 5'd1);
      for (int k = 7; k <= 15; k++) begin
         tick(); s_valid = 1'b0; #1;
         chk($sformatf("st_c%0d_stall", k), stall_req, (k == 10 || k == 15) ? 1'b1 : 1'b0);
         chk($sformatf("st_c%0d_waddr", k), rf_waddr,
             (k == 10) ? 5'd11 : ((k == 15) ? 5'd12 : 5'd1));
      end
      tick(); p_we = 1'b0; #1;
      chk("st_end_we", rf_we, 1'b0);
      chk("st_end_stall", stall_req, 1'b0);

      // Same-cycle reservation and pop of r9: set wins.
      tick(); s_valid = 1'b1; s_waddr = 5'd9; s_wdata = 32'h99; #1;
      chk("r9_push_we", rf_we, 1'b0);
      tick(); s_valid = 1'b0; rsv_en = 1'b1; rsv_addr = 5'd9; #1;
      chk("r9_pop_we", rf_we, 1'b1);
      chk("r9_pop_waddr", rf_waddr, 5'd9);
      tick(); rsv_en = 1'b0; #1;
      chk("r9_set_wins", pending[9], 1'b1);
      chk("r9_idle_we", rf_we, 1'b0);

      // Reset with two entries buffered.
      tick(); p_we = 1'b1; p_waddr = 5'd2; p_wdata = 32'h22;
      s_valid = 1'b1; s_waddr = 5'd20; s_wdata = 32'h1; #1;
      tick(); s_waddr = 5'd21; s_wdata = 32'h2; #1;
      tick(); s_valid = 1'b0; rsv_en = 1'b1; rsv_addr = 5'd21; #1;
      chk("rb_full", s_ready, 1'b0);
      tick(); rsv_en = 1'b0; rst = 1'b1; #1;
      chk("rb_pending_before", pending, 32'h0020_0200);
      chk("rb_in_rst_we", rf_we, 1'b0);
      chk("rb_in_rst_ready", s_ready, 1'b0);
      tick(); rst = 1'b0; p_we = 1'b0; #1;
      chk("rb_pending_clr", pending, 32'd0);
      chk("rb_fifo_empty", rf_we, 1'b0);
      chk("rb_ready", s_ready, 1'b1);
      chk("rb_stall", stall_req, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
